store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
// Sits directly downstream of the store queue. Pops released, byte-aligned stores from it.
// Holds them in a small FIFO, merging same-word stores, and issues them to the data-memory
// port with a req/ack handshake. Gives the load path a byte-overlap conflict check and gives
// fences a drained (empty) indication.
// PARAMETERS
// DEPTH   2   number of buffer entries; power of two, >= 2
// ADDR_W  32  byte-address width; word address = addr[ADDR_W-1:2]
// PORTS
// clk          in   1       clock
// rst          in   1       reset, synchronous, active-high
// sq_valid     in   1       store queue has a released store at its head
// sq_addr      in   ADDR_W  store byte address
// sq_be        in   4       byte enables, already lane-aligned
// sq_data      in   32      store data, already lane-aligned
// sq_pop       out  1       store accepted this cycle; drives the store queue pop
// mem_req      out  1       store request to the memory port
// mem_addr     out  ADDR_W  head entry address, with bits [1:0] forced to 0
// mem_be       out  4       head entry byte enables
// mem_data     out  32      head entry data
// mem_ack      in   1       memory accepts the request in the same cycle
// ld_check     in   1       a load is requesting a conflict check
// ld_addr      in   ADDR_W  load byte address
// ld_be        in   4       load byte enables
// ld_conflict  out  1       the load overlaps a buffered store
// empty        out  1       no buffered stores
// BEHAVIOUR
// - Storage: circular FIFO with head ptr, tail ptr and count (log2(DEPTH)+1 bits).
//   Each entry holds {word_addr, be, data}. Pointers wrap modulo DEPTH.
// - Reset:
//   - count=0, ptrs=0, so mem_req=0 and empty=1.
//   - ld_conflict=0; sq_pop follows sq_valid.
//   - Entry contents are not reset.
// - Merge condition merge_ok, all of:
//   - sq_valid=1
//   - count>=2
//   - newest entry (tail-1) has the same word address as sq_addr
//   The head is never a merge target, so the issued payload is stable.
// - On merge, for each lane b with sq_be[b]=1: data[b] <= sq_data lane b; be <= be | sq_be.
//   Count is unchanged.
// - Accept: sq_pop = sq_valid & (merge_ok | count<DEPTH).
//   - No merge: write to tail and advance tail.
//   - When full, a store is accepted only by merging. There is no push-through on a same-cycle pop.
// - Issue:
//   - mem_req = (count!=0). Payload is the head entry, combinational from registers.
//   - mem_req is held with a stable payload until mem_ack.
//   - mem_req & mem_ack: retire the head, advance head, count-1.
//   - mem_ack with mem_req=0 is ignored.
// - Latency: store accepted in cycle N while empty gives mem_req=1 in N+1. Retired at the earliest in N+1.
// - Simultaneous accept (non-merge) and retire: count unchanged, both ptrs advance.
//   A merge in the same cycle as a head retire is legal (count>=2 at cycle start).
// - Conflict check: ld_conflict = ld_check & OR over valid entries of
//   (word_addr == ld_addr word) & |(be & ld_be).
//   - Combinational.
//   - Considers buffered entries only; the store accepted this cycle is visible next cycle.
// - empty = (count==0). Registered state only.
// - Reset mid-operation: all entries are discarded. mem_req drops in the cycle after rst is sampled.
//   The memory port must tolerate abandoned requests.
// - Assertions:
//   - no accept when full and not merging;
//   - mem_req payload stable while mem_req & ~mem_ack.
// TESTING
// - Empty, mem_ack=1; push addr 0x100, be 0xF, data 0xAABBCCDD -> sq_pop=1 in N;
//   mem_req=1, mem_addr=0x100 in N+1; empty=1 in N+2.
// - mem_ack=0; push 0x200 be 0x1, 0x300 be 0x1, then 0x302 be 0x4 data 0x00EE0000
//   -> entry1 be=0x5, data byte2=0xEE; sq_pop=1 while full.
// - DEPTH=2 full with mem_ack=0; push 0x400 -> sq_pop=0.
//   Raise mem_ack -> head retires; the push is accepted the next cycle.
// - Buffered 0x500 be 0x3; ld_check 0x502 be 0xC -> ld_conflict=0.
//   ld_check 0x501 be 0x2 -> ld_conflict=1.
// - Two entries pending; rst high 1 cycle -> mem_req=0, empty=1 next cycle.
//   A new push then issues normally.
// - Random valid/ack stress for 10k cycles -> memory writes match a golden in-order byte-merge model.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of released stores between the store queue and the data-memory
// port, merging same-word stores into the newest entry and offering a load conflict check.
module store_write_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sq_valid,
  input  logic [ADDR_W-1:0] sq_addr,
  input  logic [3:0]        sq_be,
  input  logic [31:0]       sq_data,
  output logic              sq_pop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  input  logic              ld_check,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_be,
  output logic              ld_conflict,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]  word_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, newest;
  logic [CNT_W-1:0] count_q;
  logic [WA_W-1:0]  sq_word, ld_word;
  logic             merge_ok, push, retire;
  logic [PTR_W-1:0] offset;
  logic             unused_low_bits;

  assign sq_word = sq_addr[ADDR_W-1:2];
  assign ld_word = ld_addr[ADDR_W-1:2];
  assign unused_low_bits = ^{sq_addr[1:0], ld_addr[1:0]};

  // The head is never merged into (count >= 2), so the issued payload cannot change.
  assign newest   = tail_q - PTR_W'(1);
  assign merge_ok = sq_valid && (count_q >= CNT_W'(2)) && (word_q[newest] == sq_word);
  assign sq_pop   = sq_valid && (merge_ok || (count_q < CNT_W'(DEPTH)));
  assign push     = sq_pop && !merge_ok;

  assign mem_req  = (count_q != '0);
  assign retire   = mem_req && mem_ack;
  assign mem_addr = {word_q[head_q], 2'b00};
  assign mem_be   = be_q[head_q];
  assign mem_data = data_q[head_q];
  assign empty    = (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)   tail_q <= tail_q + PTR_W'(1);
      if (retire) head_q <= head_q + PTR_W'(1);
      case ({push, retire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payloads are not reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail_q] <= sq_word;
      be_q[tail_q]   <= sq_be;
      data_q[tail_q] <= sq_data;
    end else if (merge_ok) begin
      be_q[newest] <= be_q[newest] | sq_be;
      for (int b = 0; b < 4; b++) begin
        if (sq_be[b]) data_q[newest][8*b +: 8] <= sq_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (ld_check && ({1'b0, offset} < count_q) && (word_q[i] == ld_word) &&
          (|(be_q[i] & ld_be))) begin
        ld_conflict = 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (sq_pop && !merge_ok) |-> (count_q < CNT_W'(DEPTH)));

  a_payload_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ack) |=> (!mem_req || $stable({mem_addr, mem_be, mem_data})));

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed and random checks of store_write_buffer (DEPTH=2): latency, merge, full stall,
// load conflicts, mid-run reset and an in-order byte-merge memory model.
module tb_store_write_buffer;

  logic        clk, rst;
  logic        sq_valid, sq_pop;
  logic [31:0] sq_addr, sq_data;
  logic [3:0]  sq_be;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_be;
  logic        ld_check, ld_conflict, empty;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] gold [16];
  logic [7:0] dmem [16];

  store_write_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_be(sq_be), .sq_data(sq_data), .sq_pop(sq_pop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_data(mem_data),
    .mem_ack(mem_ack),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_be(ld_be), .ld_conflict(ld_conflict),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sq(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    sq_valid = 1'b1; sq_addr = a; sq_be = be; sq_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; sq_valid = 1'b0; mem_ack = 1'b0; ld_check = 1'b0;
    sq_addr = '0; sq_be = '0; sq_data = '0; ld_addr = '0; ld_be = '0;
    tick(); tick();
    rst = 1'b0;
    sq_valid = 1'b1; sq_be = 4'hF; ld_check = 1'b1; ld_be = 4'hF;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0h want 1", empty); end
    n_cmp++; if (sq_pop !== 1'b1) begin n_err++; $display("FAIL rst_sq_pop: got %0h want 1", sq_pop); end
    n_cmp++; if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL rst_ld_conflict: got %0h want 0", ld_conflict); end
    sq_valid = 1'b0; ld_check = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    mem_ack = 1'b1;
    drive_sq(32'h100, 4'hF, 32'hAABBCCDD);
    @(negedge clk);
    n_cmp++; if (sq_pop !== 1'b1) begin n_err++; $display("FAIL lat_sq_pop: got %0h want 1", sq_pop); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lat_req_n: got %0h want 0", mem_req); end
    tick();
    sq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL lat_req_n1: got %0h want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL lat_addr: got %0h want 100", mem_addr); end
    n_cmp++; if (mem_be !== 4'hF) begin n_err++; $display("FAIL lat_be: got %0h want f", mem_be); end
    n_cmp++; if (mem_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL lat_data: got %0h want aabbccdd", mem_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL lat_empty_n2: got %0h want 1", empty); end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_merge();
    mem_ack = 1'b0;
    drive_sq(32'h200, 4'h1, 32'h0000_0011);
    tick();
    drive_sq(32'h300, 4'h1, 32'h0000_0022);
    tick();
    drive_sq(32'h302, 4'h4, 32'h00EE_0000);
    @(negedge clk);
    n_cmp++; if (sq_pop !== 1'b1) begin n_err++; $display("FAIL merge_pop_full: got %0h want 1", sq_pop); end
    tick();
    sq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h200) begin n_err++; $display("FAIL merge_head_addr: got %0h want 200", mem_addr); end
    n_cmp++; if (mem_be !== 4'h1) begin n_err++; $display("FAIL merge_head_be: got %0h want 1", mem_be); end
    mem_ack = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h300) begin n_err++; $display("FAIL merge_addr: got %0h want 300", mem_addr); end
    n_cmp++; if (mem_be !== 4'h5) begin n_err++; $display("FAIL merge_be: got %0h want 5", mem_be); end
    n_cmp++; if (mem_data !== 32'h00EE_0022) begin n_err++; $display("FAIL merge_data: got %0h want ee0022", mem_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL merge_drained: got %0h want 1", empty); end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_full_stall();
    mem_ack = 1'b0;
    drive_sq(32'h410, 4'hF, 32'h1);
    tick();
    drive_sq(32'h420, 4'hF, 32'h2);
    tick();
    drive_sq(32'h400, 4'hF, 32'h3);
    @(negedge clk);
    n_cmp++; if (sq_pop !== 1'b0) begin n_err++; $display("FAIL full_pop: got %0h want 0", sq_pop); end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (sq_pop !== 1'b0) begin n_err++; $display("FAIL full_no_pushthrough: got %0h want 0", sq_pop); end
    n_cmp++; if (mem_addr !== 32'h410) begin n_err++; $display("FAIL full_head: got %0h want 410", mem_addr); end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (sq_pop !== 1'b1) begin n_err++; $display("FAIL full_pop_after: got %0h want 1", sq_pop); end
    n_cmp++; if (mem_addr !== 32'h420) begin n_err++; $display("FAIL full_head2: got %0h want 420", mem_addr); end
    tick();
    sq_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h400) begin n_err++; $display("FAIL full_head3: got %0h want 400", mem_addr); end
    n_cmp++; if (mem_data !== 32'h3) begin n_err++; $display("FAIL full_data3: got %0h want 3", mem_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_drained: got %0h want 1", empty); end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    mem_ack = 1'b0;
    drive_sq(32'h500, 4'h3, 32'h0000_1234);
    tick();
    sq_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h502; ld_be = 4'hC;
    #1;
    n_cmp++; if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL cf_disjoint: got %0h want 0", ld_conflict); end
    ld_addr = 32'h501; ld_be = 4'h2;
    #1;
    n_cmp++; if (ld_conflict !== 1'b1) begin n_err++; $display("FAIL cf_overlap: got %0h want 1", ld_conflict); end
    ld_check = 1'b0;
    #1;
    n_cmp++; if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL cf_no_check: got %0h want 0", ld_conflict); end
    ld_check = 1'b1; ld_addr = 32'h600; ld_be = 4'hF;
    #1;
    n_cmp++; if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL cf_other_word: got %0h want 0", ld_conflict); end
    ld_addr = 32'h700;
    drive_sq(32'h700, 4'hF, 32'h5);
    #1;
    n_cmp++; if (ld_conflict !== 1'b0) begin n_err++; $display("FAIL cf_same_cycle: got %0h want 0", ld_conflict); end
    tick();
    sq_valid = 1'b0;
    #1;
    n_cmp++; if (ld_conflict !== 1'b1) begin n_err++; $display("FAIL cf_next_cycle: got %0h want 1", ld_conflict); end
    ld_check = 1'b0;
    mem_ack = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL cf_drained: got %0h want 1", empty); end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b0;
    drive_sq(32'h800, 4'hF, 32'h8);
    tick();
    drive_sq(32'h900, 4'hF, 32'h9);
    tick();
    sq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_pending: got %0h want 1", mem_req); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rm_req: got %0h want 0", mem_req); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_empty: got %0h want 1", empty); end
    tick();
    drive_sq(32'hA00, 4'hF, 32'h1234_5678);
    tick();
    sq_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_new_req: got %0h want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'hA00) begin n_err++; $display("FAIL rm_new_addr: got %0h want a00", mem_addr); end
    n_cmp++; if (mem_data !== 32'h1234_5678) begin n_err++; $display("FAIL rm_new_data: got %0h want 12345678", mem_data); end
    mem_ack = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_drained: got %0h want 1", empty); end
    mem_ack = 1'b0;
    tick();
  endtask

  // Apply accepted stores to gold and issued writes to dmem, both at the negedge sample point.
  task automatic sample_stress();
    @(negedge clk);
    if (sq_pop) begin
      for (int b = 0; b < 4; b++)
        if (sq_be[b]) gold[{sq_addr[3:2], 2'(b)}] = sq_data[8*b +: 8];
    end
    if (mem_req && mem_ack) begin
      n_cmp++;
      if ({mem_addr[31:4], mem_addr[1:0]} !== {28'h100, 2'b00}) begin
        n_err++; $display("FAIL st_mem_addr: got %0h want 10%0h0", mem_addr, mem_addr[3:2]);
      end
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[{mem_addr[3:2], 2'(b)}] = mem_data[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stress();
    for (int i = 0; i < 16; i++) begin gold[i] = 8'h0; dmem[i] = 8'h0; end
    for (int c = 0; c < 10000; c++) begin
      sq_valid = ($urandom_range(0, 3) != 0);
      sq_addr  = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      sq_be    = 4'($urandom_range(1, 15));
      sq_data  = $urandom;
      mem_ack  = ($urandom_range(0, 2) == 0);
      sample_stress();
    end
    sq_valid = 1'b0;
    mem_ack  = 1'b1;
    for (int k = 0; k < 8; k++) sample_stress();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL st_drain: got %0h want 1", empty); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dmem[i] !== gold[i]) begin
        n_err++; $display("FAIL st_byte%0d: got %0h want %0h", i, dmem[i], gold[i]);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_merge();
    test_full_stall();
    test_conflict();
    test_reset_mid();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
